// File: rtl/uart_ip_core.sv
// Full-duplex UART: shared baud tick generator, TX/RX FIFOs, frame serializer and deserializer.
// Single clock domain; UART_RX_I is resynchronized before use.

module uart_ip_core #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned DATA_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_tx_fifo_empty,
  input  logic              en_tx_fifo_full,
  input  logic              en_rx_fifo_empty,
  input  logic              en_rx_fifo_full,
  input  logic              tx_flag,
  input  logic              rx_flag,
  input  logic              PEN,
  input  logic              EPS,
  input  logic              STB,
  input  logic              BGE,
  input  logic              OSM_SEL,
  input  logic [1:0]        WLS,
  input  logic [DATA_W-1:0] TBR_i,
  input  logic [7:0]        DLH,
  input  logic [7:0]        DLL,
  input  logic              UART_RX_I,
  output logic              UART_TX_O,
  output logic [DATA_W-1:0] RBR_o,
  output logic              tx_fifo_empty,
  output logic              tx_fifo_full,
  output logic              rx_fifo_empty,
  output logic              rx_fifo_full
);
  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam int unsigned PTR_W = AW + 1;
  localparam int unsigned DIV_W = 16;
  localparam int unsigned TCN_W = 4;
  localparam int unsigned BIT_W = 3;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} frame_state_t;

  // Interrupt enables are reserved and intentionally unused.
  logic unused_en;
  assign unused_en = ^{en_tx_fifo_empty, en_tx_fifo_full, en_rx_fifo_empty, en_rx_fifo_full};

  // Baud tick generator: one-clock tick every {DLH,DLL} clocks.
  logic [DIV_W-1:0] div_c, baud_cnt;
  logic             baud_on_c, tick_c;

  assign div_c     = {DLH, DLL};
  assign baud_on_c = BGE && (div_c != '0);
  assign tick_c    = baud_on_c && (baud_cnt >= div_c - DIV_W'(1));

  always_ff @(posedge clk) begin
    if (!rst_n || !baud_on_c) baud_cnt <= '0;
    else if (tick_c)          baud_cnt <= '0;
    else                      baud_cnt <= baud_cnt + DIV_W'(1);
  end

  // Two FIFOs: index 0 is TX, index 1 is RX.
  logic [1:0]        fifo_push, fifo_pop, fifo_empty, fifo_full;
  logic [DATA_W-1:0] fifo_din  [2];
  logic [DATA_W-1:0] fifo_head [2];
  logic              tx_pop_c, rx_push_c;
  logic [DATA_W-1:0] rx_data;

  assign fifo_push   = {rx_push_c, tx_flag};
  assign fifo_pop    = {rx_flag, tx_pop_c};
  assign fifo_din[0] = TBR_i;
  assign fifo_din[1] = rx_data;

  for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wptr, rptr, wptr_nxt, rptr_nxt;
    logic              do_push, do_pop, empty_q, full_q;

    always_comb begin
      do_push  = fifo_push[gi] && !full_q;
      do_pop   = fifo_pop[gi] && !empty_q;
      wptr_nxt = wptr + PTR_W'(do_push);
      rptr_nxt = rptr + PTR_W'(do_pop);
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        wptr    <= '0;
        rptr    <= '0;
        empty_q <= 1'b1;
        full_q  <= 1'b0;
      end else begin
        wptr    <= wptr_nxt;
        rptr    <= rptr_nxt;
        empty_q <= (wptr_nxt == rptr_nxt);
        full_q  <= (wptr_nxt[AW] != rptr_nxt[AW]) && (wptr_nxt[AW-1:0] == rptr_nxt[AW-1:0]);
      end
    end

    always_ff @(posedge clk) begin
      if (do_push) mem[wptr[AW-1:0]] <= fifo_din[gi];
    end

    assign fifo_head[gi]  = mem[rptr[AW-1:0]];
    assign fifo_empty[gi] = empty_q;
    assign fifo_full[gi]  = full_q;
  end

  assign tx_fifo_empty = fifo_empty[0];
  assign tx_fifo_full  = fifo_full[0];
  assign rx_fifo_empty = fifo_empty[1];
  assign rx_fifo_full  = fifo_full[1];

  always_ff @(posedge clk) begin
    if (!rst_n)                         RBR_o <= '0;
    else if (rx_flag && !fifo_empty[1]) RBR_o <= fifo_head[1];
  end

  // Transmitter: frames start on a tick so every bit lasts exactly OSM ticks.
  frame_state_t      tx_state, tx_state_nxt;
  logic [TCN_W-1:0]  tx_tcnt, tx_tcnt_nxt;
  logic [BIT_W-1:0]  tx_bitn, tx_bitn_nxt;
  logic [DATA_W-1:0] tx_shift, tx_shift_nxt, tx_masked_c;
  logic [1:0]        tx_wls, tx_wls_nxt;
  logic              tx_par, tx_par_nxt, tx_stop2, tx_stop2_nxt;
  logic              tx_pen, tx_pen_nxt, tx_stb, tx_stb_nxt, tx_osm, tx_osm_nxt;
  logic              tx_line_nxt, tx_bit_end_c, tx_load_c;

  assign tx_masked_c = fifo_head[0] & ({DATA_W{1'b1}} >> (2'd3 - WLS));

  always_comb begin
    tx_state_nxt = tx_state;
    tx_tcnt_nxt  = tx_tcnt;
    tx_bitn_nxt  = tx_bitn;
    tx_shift_nxt = tx_shift;
    tx_par_nxt   = tx_par;
    tx_stop2_nxt = tx_stop2;
    tx_wls_nxt   = tx_wls;
    tx_pen_nxt   = tx_pen;
    tx_stb_nxt   = tx_stb;
    tx_osm_nxt   = tx_osm;
    tx_line_nxt  = UART_TX_O;
    tx_pop_c     = 1'b0;
    tx_load_c    = 1'b0;
    tx_bit_end_c = tick_c && (tx_tcnt == (tx_osm ? 4'd12 : 4'd15));
    if (tick_c && tx_state != S_IDLE) tx_tcnt_nxt = tx_bit_end_c ? '0 : tx_tcnt + TCN_W'(1);
    case (tx_state)
      S_IDLE:  if (tick_c && !fifo_empty[0]) tx_load_c = 1'b1;
      S_START: if (tx_bit_end_c) begin
        tx_state_nxt = S_DATA;
        tx_bitn_nxt  = '0;
        tx_line_nxt  = tx_shift[0];
      end
      S_DATA: if (tx_bit_end_c) begin
        if (tx_bitn == BIT_W'(tx_wls) + BIT_W'(4)) begin
          if (tx_pen) begin
            tx_state_nxt = S_PARITY;
            tx_line_nxt  = tx_par;
          end else begin
            tx_state_nxt = S_STOP;
            tx_stop2_nxt = 1'b0;
            tx_line_nxt  = 1'b1;
          end
        end else begin
          tx_bitn_nxt  = tx_bitn + BIT_W'(1);
          tx_shift_nxt = tx_shift >> 1;
          tx_line_nxt  = tx_shift[1];
        end
      end
      S_PARITY: if (tx_bit_end_c) begin
        tx_state_nxt = S_STOP;
        tx_stop2_nxt = 1'b0;
        tx_line_nxt  = 1'b1;
      end
      S_STOP: if (tx_bit_end_c) begin
        if (tx_stb && !tx_stop2) tx_stop2_nxt = 1'b1;
        else if (!fifo_empty[0]) tx_load_c    = 1'b1;
        else begin
          tx_state_nxt = S_IDLE;
          tx_line_nxt  = 1'b1;
        end
      end
      default: tx_state_nxt = S_IDLE;
    endcase
    // Frame start: pop the head and freeze the frame configuration.
    if (tx_load_c) begin
      tx_pop_c     = 1'b1;
      tx_state_nxt = S_START;
      tx_tcnt_nxt  = '0;
      tx_line_nxt  = 1'b0;
      tx_shift_nxt = tx_masked_c;
      tx_par_nxt   = (^tx_masked_c) ^ ~EPS;
      tx_wls_nxt   = WLS;
      tx_pen_nxt   = PEN;
      tx_stb_nxt   = STB;
      tx_osm_nxt   = OSM_SEL;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_state  <= S_IDLE;
      tx_tcnt   <= '0;
      tx_bitn   <= '0;
      tx_shift  <= '0;
      tx_par    <= 1'b0;
      tx_stop2  <= 1'b0;
      tx_wls    <= '0;
      tx_pen    <= 1'b0;
      tx_stb    <= 1'b0;
      tx_osm    <= 1'b0;
      UART_TX_O <= 1'b1;
    end else begin
      tx_state  <= tx_state_nxt;
      tx_tcnt   <= tx_tcnt_nxt;
      tx_bitn   <= tx_bitn_nxt;
      tx_shift  <= tx_shift_nxt;
      tx_par    <= tx_par_nxt;
      tx_stop2  <= tx_stop2_nxt;
      tx_wls    <= tx_wls_nxt;
      tx_pen    <= tx_pen_nxt;
      tx_stb    <= tx_stb_nxt;
      tx_osm    <= tx_osm_nxt;
      UART_TX_O <= tx_line_nxt;
    end
  end

  // Receiver: mid-bit sampling referenced to the synchronized start edge.
  frame_state_t      rx_state, rx_state_nxt;
  logic [TCN_W-1:0]  rx_tcnt, rx_tcnt_nxt;
  logic [BIT_W-1:0]  rx_bitn, rx_bitn_nxt;
  logic [DATA_W-1:0] rx_data_nxt;
  logic [1:0]        rx_wls, rx_wls_nxt;
  logic              rx_pen, rx_pen_nxt, rx_stb, rx_stb_nxt, rx_osm, rx_osm_nxt;
  logic              rx_stop2, rx_stop2_nxt;
  logic              rx_sync1, rx_sync2, rx_prev, rx_samp_c;

  always_comb begin
    rx_state_nxt = rx_state;
    rx_tcnt_nxt  = rx_tcnt;
    rx_bitn_nxt  = rx_bitn;
    rx_data_nxt  = rx_data;
    rx_stop2_nxt = rx_stop2;
    rx_wls_nxt   = rx_wls;
    rx_pen_nxt   = rx_pen;
    rx_stb_nxt   = rx_stb;
    rx_osm_nxt   = rx_osm;
    rx_push_c    = 1'b0;
    rx_samp_c    = tick_c && (rx_tcnt == (rx_osm ? 4'd12 : 4'd15));
    if (tick_c && rx_state != S_IDLE && rx_state != S_START)
      rx_tcnt_nxt = rx_samp_c ? '0 : rx_tcnt + TCN_W'(1);
    case (rx_state)
      S_IDLE: if (rx_prev && !rx_sync2) begin
        rx_state_nxt = S_START;
        rx_tcnt_nxt  = '0;
        rx_data_nxt  = '0;
        rx_wls_nxt   = WLS;
        rx_pen_nxt   = PEN;
        rx_stb_nxt   = STB;
        rx_osm_nxt   = OSM_SEL;
      end
      S_START: if (tick_c) begin
        if (rx_tcnt == (rx_osm ? 4'd5 : 4'd7)) begin
          rx_tcnt_nxt  = '0;
          rx_bitn_nxt  = '0;
          rx_state_nxt = rx_sync2 ? S_IDLE : S_DATA;
        end else begin
          rx_tcnt_nxt = rx_tcnt + TCN_W'(1);
        end
      end
      S_DATA: if (rx_samp_c) begin
        rx_data_nxt[rx_bitn] = rx_sync2;
        if (rx_bitn == BIT_W'(rx_wls) + BIT_W'(4)) begin
          rx_state_nxt = rx_pen ? S_PARITY : S_STOP;
          rx_stop2_nxt = 1'b0;
        end else begin
          rx_bitn_nxt = rx_bitn + BIT_W'(1);
        end
      end
      S_PARITY: if (rx_samp_c) begin
        rx_state_nxt = S_STOP;
        rx_stop2_nxt = 1'b0;
      end
      S_STOP: if (rx_samp_c) begin
        if (!rx_stop2) rx_push_c = 1'b1;
        if (rx_stb && !rx_stop2) rx_stop2_nxt = 1'b1;
        else                     rx_state_nxt = S_IDLE;
      end
      default: rx_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_sync1 <= 1'b1;
      rx_sync2 <= 1'b1;
      rx_prev  <= 1'b1;
      rx_state <= S_IDLE;
      rx_tcnt  <= '0;
      rx_bitn  <= '0;
      rx_data  <= '0;
      rx_stop2 <= 1'b0;
      rx_wls   <= '0;
      rx_pen   <= 1'b0;
      rx_stb   <= 1'b0;
      rx_osm   <= 1'b0;
    end else begin
      rx_sync1 <= UART_RX_I;
      rx_sync2 <= rx_sync1;
      rx_prev  <= rx_sync2;
      rx_state <= rx_state_nxt;
      rx_tcnt  <= rx_tcnt_nxt;
      rx_bitn  <= rx_bitn_nxt;
      rx_data  <= rx_data_nxt;
      rx_stop2 <= rx_stop2_nxt;
      rx_wls   <= rx_wls_nxt;
      rx_pen   <= rx_pen_nxt;
      rx_stb   <= rx_stb_nxt;
      rx_osm   <= rx_osm_nxt;
    end
  end
endmodule

// File: tb/tb_uart_ip_core.sv
// Directed bench for uart_ip_core: reset, TX framing/timing, parity/stop, FIFO limits,
// loopback, RX overflow, start-bit glitch rejection and mid-frame reset.

module tb_uart_ip_core;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       tx_flag, rx_flag, PEN, EPS, STB, BGE, OSM_SEL;
  logic [1:0] WLS;
  logic [7:0] TBR_i, DLH, DLL, RBR_o;
  logic       UART_RX_I, UART_TX_O;
  logic       tx_fifo_empty, tx_fifo_full, rx_fifo_empty, rx_fifo_full;
  logic       loop_en, rx_drive;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;
  assign UART_RX_I = loop_en ? UART_TX_O : rx_drive;

  uart_ip_core dut (
    .clk(clk), .rst_n(rst_n),
    .en_tx_fifo_empty(1'b0), .en_tx_fifo_full(1'b0),
    .en_rx_fifo_empty(1'b0), .en_rx_fifo_full(1'b0),
    .tx_flag(tx_flag), .rx_flag(rx_flag),
    .PEN(PEN), .EPS(EPS), .STB(STB), .BGE(BGE), .OSM_SEL(OSM_SEL), .WLS(WLS),
    .TBR_i(TBR_i), .DLH(DLH), .DLL(DLL),
    .UART_RX_I(UART_RX_I), .UART_TX_O(UART_TX_O), .RBR_o(RBR_o),
    .tx_fifo_empty(tx_fifo_empty), .tx_fifo_full(tx_fifo_full),
    .rx_fifo_empty(rx_fifo_empty), .rx_fifo_full(rx_fifo_full)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick_clks(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [7:0] v);
    TBR_i   = v;
    tx_flag = 1'b1;
    tick_clks(1);
    tx_flag = 1'b0;
  endtask

  task automatic pop(output logic [7:0] v);
    rx_flag = 1'b1;
    tick_clks(1);
    rx_flag = 1'b0;
    v = RBR_o;
  endtask

  task automatic set_div(input int d);
    {DLH, DLL} = 16'(d);
  endtask

  task automatic wait_fall(input int limit, output int n, output logic ok);
    n  = 0;
    ok = 1'b0;
    while (!ok && n < limit) begin
      tick_clks(1);
      n++;
      if (UART_TX_O === 1'b0) ok = 1'b1;
    end
  endtask

  // Called just after a start edge; data bit 0 must be 1 so the start length is measurable.
  task automatic check_bits(input string tag, input int bit_clks, input int nbits, input logic [15:0] pat);
    int          n;
    logic [15:0] got;
    n   = 0;
    got = '0;
    while (UART_TX_O === 1'b0 && n < 4 * bit_clks) begin
      tick_clks(1);
      n++;
    end
    check({tag, "_start_len"}, 32'(n), 32'(bit_clks));
    tick_clks(bit_clks / 2);
    for (int i = 0; i < nbits; i++) begin
      if (i > 0) tick_clks(bit_clks);
      got[i] = UART_TX_O;
    end
    check({tag, "_bits"}, 32'(got), 32'(pat));
  endtask

  task automatic send_serial(input logic [7:0] b, input int bit_clks);
    rx_drive = 1'b0;
    tick_clks(bit_clks);
    for (int i = 0; i < 8; i++) begin
      rx_drive = b[i];
      tick_clks(bit_clks);
    end
    rx_drive = 1'b1;
    tick_clks(bit_clks);
  endtask

  task automatic loopback(input int n, input int d);
    logic [7:0] sent_q[$];
    logic [7:0] mask, b;
    int         sent, got, cyc, limit;
    sent  = 0;
    got   = 0;
    cyc   = 0;
    limit = n * 12 * 16 * d + 2000;
    mask  = 8'((1 << (int'(WLS) + 5)) - 1);
    set_div(d);
    BGE = 1'b1;
    while (got < n && cyc < limit) begin
      tx_flag = (sent < n) && !tx_fifo_full;
      if (tx_flag) begin
        b = 8'($urandom);
        TBR_i = b;
        sent_q.push_back(b & mask);
        sent++;
      end
      rx_flag = !rx_fifo_empty;
      tick_clks(1);
      cyc++;
      if (rx_flag) begin
        if (sent_q.size() == 0) check("loop_extra", 32'(1), 32'(0));
        else                    check("loop_data", 32'(RBR_o), 32'(sent_q.pop_front()));
        got++;
      end
    end
    tx_flag = 1'b0;
    rx_flag = 1'b0;
    check("loop_count", 32'(got), 32'(n));
  endtask

  initial begin
    repeat (200000) @(posedge clk);
    $display("FAIL watchdog: cycle budget exhausted");
    $fatal(1, "watchdog");
  end

  initial begin
    int         n;
    logic       ok;
    logic [7:0] v;
    logic [7:0] vals[16];

    rst_n = 1'b0; tx_flag = 1'b0; rx_flag = 1'b0;
    PEN = 1'b0; EPS = 1'b0; STB = 1'b0; BGE = 1'b0; OSM_SEL = 1'b0; WLS = 2'b11;
    TBR_i = '0; DLH = '0; DLL = '0; loop_en = 1'b0; rx_drive = 1'b1;

    // Reset state
    tick_clks(200);
    check("rst_tx_line", 32'(UART_TX_O), 32'(1));
    check("rst_tx_empty", 32'(tx_fifo_empty), 32'(1));
    check("rst_rx_empty", 32'(rx_fifo_empty), 32'(1));
    check("rst_tx_full", 32'(tx_fifo_full), 32'(0));
    check("rst_rx_full", 32'(rx_fifo_full), 32'(0));
    check("rst_rbr", 32'(RBR_o), 32'(0));
    rst_n = 1'b1;
    tick_clks(5);

    // 8N1 framing at D=27: 432-clk bits at 16x, 351-clk bits at 13x
    set_div(27); BGE = 1'b1;
    push(8'hA5);
    wait_fall(1000, n, ok);
    check("f16_fall", 32'(ok), 32'(1));
    check_bits("f16", 432, 9, 16'h1A5);
    OSM_SEL = 1'b1;
    push(8'hA5);
    wait_fall(1000, n, ok);
    check("f13_fall", 32'(ok), 32'(1));
    check_bits("f13", 351, 9, 16'h1A5);
    tick_clks(400);

    // 5-bit parity frames with two stop bits; EPS changes mid-frame only affects frame 2
    set_div(4); OSM_SEL = 1'b0; WLS = 2'b00; PEN = 1'b1; EPS = 1'b1; STB = 1'b1;
    push(8'h13);
    push(8'h13);
    wait_fall(1000, n, ok);
    check("par_even_fall", 32'(ok), 32'(1));
    EPS = 1'b0;
    check_bits("par_even", 64, 8, 16'h00F3);
    wait_fall(1000, n, ok);
    check("stop2_gap", 32'(n), 32'(32));
    check_bits("par_odd", 64, 8, 16'h00D3);
    tick_clks(200);

    // TX FIFO fill with baud generator off: 16 accepted, 17th dropped
    BGE = 1'b0; set_div(2); WLS = 2'b11; PEN = 1'b0; STB = 1'b0;
    for (int i = 0; i < 16; i++) begin
      vals[i] = 8'(i * 34 + 1);
      push(vals[i]);
      if (i == 14) check("txf_not_full15", 32'(tx_fifo_full), 32'(0));
    end
    check("txf_full16", 32'(tx_fifo_full), 32'(1));
    check("txf_not_empty", 32'(tx_fifo_empty), 32'(0));
    push(8'hEF);
    check("txf_full17", 32'(tx_fifo_full), 32'(1));
    BGE = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wait_fall(200, n, ok);
      check("txf_frame_fall", 32'(ok), 32'(1));
      check_bits("txf_frame", 32, 9, {7'b0, 1'b1, vals[i]});
    end
    wait_fall(1000, n, ok);
    check("txf_no_17th", 32'(ok), 32'(0));
    check("txf_drained", 32'(tx_fifo_empty), 32'(1));

    // Loopback: one 8N1 round at D=27, then random configs at fast divisors
    loop_en = 1'b1;
    WLS = 2'b11; PEN = 1'b0; STB = 1'b0; OSM_SEL = 1'b0;
    loopback(2, 27);
    for (int r = 0; r < 2; r++) begin
      tick_clks(1000);
      WLS = 2'($urandom_range(3, 0));
      PEN = 1'($urandom_range(1, 0));
      EPS = 1'($urandom_range(1, 0));
      STB = 1'($urandom_range(1, 0));
      OSM_SEL = 1'($urandom_range(1, 0));
      loopback(20, int'($urandom_range(3, 2)));
    end
    tick_clks(1000);

    // RX overflow: 17 frames without popping, first 16 kept in order
    loop_en = 1'b0; rx_drive = 1'b1;
    WLS = 2'b11; PEN = 1'b0; STB = 1'b0; OSM_SEL = 1'b0; set_div(2);
    tick_clks(100);
    for (int i = 0; i < 16; i++) begin
      vals[i] = 8'(8'h80 + i * 7);
      send_serial(vals[i], 32);
    end
    check("rxf_full16", 32'(rx_fifo_full), 32'(1));
    send_serial(8'hFF, 32);
    check("rxf_full17", 32'(rx_fifo_full), 32'(1));
    for (int i = 0; i < 16; i++) begin
      pop(v);
      check("rxf_data", 32'(v), 32'(vals[i]));
    end
    check("rxf_empty", 32'(rx_fifo_empty), 32'(1));
    pop(v);
    check("rxf_pop_empty_hold", 32'(v), 32'(vals[15]));

    // Start-bit glitch shorter than half a bit is rejected
    rx_drive = 1'b0;
    tick_clks(6);
    rx_drive = 1'b1;
    tick_clks(300);
    check("glitch_no_push", 32'(rx_fifo_empty), 32'(1));
    send_serial(8'h5A, 32);
    pop(v);
    check("after_glitch", 32'(v), 32'(8'h5A));

    // Reset in the middle of TX and RX frames
    push(8'h81);
    rx_drive = 1'b0;
    tick_clks(32);
    rx_drive = 1'b1;
    tick_clks(40);
    rst_n = 1'b0;
    tick_clks(3);
    check("mid_rst_tx_line", 32'(UART_TX_O), 32'(1));
    check("mid_rst_tx_empty", 32'(tx_fifo_empty), 32'(1));
    check("mid_rst_rbr", 32'(RBR_o), 32'(0));
    rst_n = 1'b1;
    tick_clks(400);
    check("abort_rx_empty", 32'(rx_fifo_empty), 32'(1));
    check("abort_tx_idle", 32'(UART_TX_O), 32'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_ip_core.md
Name: uart_ip_core

Overview:
- Full-duplex UART: programmable baud generator, 16-entry TX FIFO feeding a serializer, and a deserializer feeding a 16-entry RX FIFO.
- Sits between a register/bus front end (which supplies config, data and push/pop strobes) and the serial pins.
- Frame format: 5–8 data bits, optional parity, 1 or 2 stop bits, 13x or 16x oversampling.

Parameters:
- FIFO_DEPTH, 16, entries per TX and RX FIFO; power of two.
- DATA_W, 8, FIFO and character width.

Ports:
- clk  in  1  system clock; single clock domain.
- rst_n  in  1  reset, synchronous, active-low.
- en_tx_fifo_empty  in  1  interrupt-enable bit, reserved; no effect on any output.
- en_tx_fifo_full  in  1  interrupt-enable bit, reserved; no effect on any output.
- en_rx_fifo_empty  in  1  interrupt-enable bit, reserved; no effect on any output.
- en_rx_fifo_full  in  1  interrupt-enable bit, reserved; no effect on any output.
- tx_flag  in  1  push TBR_i into TX FIFO; one push per cycle high.
- rx_flag  in  1  pop RX FIFO into RBR_o; one pop per cycle high.
- PEN  in  1  parity enable.
- EPS  in  1  1 = even parity, 0 = odd parity.
- STB  in  1  0 = one stop bit, 1 = two stop bits.
- BGE  in  1  baud generator enable.
- OSM_SEL  in  1  0 = 16x oversampling, 1 = 13x oversampling.
- WLS  in  2  word length: 00 = 5, 01 = 6, 10 = 7, 11 = 8 bits.
- TBR_i  in  8  transmit data.
- DLH  in  8  divisor high byte.
- DLL  in  8  divisor low byte.
- UART_RX_I  in  1  serial input; asynchronous to clk.
- UART_TX_O  out  1  serial output.
- RBR_o  out  8  receive data.
- tx_fifo_empty  out  1  TX FIFO status.
- tx_fifo_full  out  1  TX FIFO status.
- rx_fifo_empty  out  1  RX FIFO status.
- rx_fifo_full  out  1  RX FIFO status.

Behaviour:

Reset (rst_n low at a clk edge):
- FIFOs emptied: tx_fifo_empty = 1, rx_fifo_empty = 1, both full flags = 0.
- RBR_o = 0; UART_TX_O = 1 (idle mark).
- Baud counter and both FSMs return to IDLE.
- Reset mid-frame aborts the frame; no partial character is stored.

Baud generator:
- D = {DLH, DLL}.
- With BGE = 1 and D != 0, a counter produces a one-clk tick every D clocks.
- BGE = 0 or D = 0: no ticks; counter held at 0.
- One bit time = OSM ticks, where OSM = 16 (OSM_SEL = 0) or 13 (OSM_SEL = 1).

FIFOs:
- Synchronous; 5-bit pointers with wrap bit.
- full = (count == 16); empty = (count == 0); status flags are registered from the pointers, not masked by the en_* inputs.
- Push when full: ignored. Pop when empty: ignored, RBR_o holds its value.
- Simultaneous push and pop on a non-empty, non-full FIFO: both performed, count unchanged.
- RBR_o is registered: on a clk edge with rx_flag = 1 and RX FIFO not empty, RBR_o <= head entry and the read pointer advances. The value is valid the cycle after the pop.

Transmitter FSM (IDLE, START, DATA, PARITY, STOP):
- IDLE: when the TX FIFO is not empty, pop one entry and go to START.
- START: drive 0 for one bit time.
- DATA: drive WLS+5 data bits, LSB first.
- PARITY (only if PEN = 1): drive XOR of the data bits, inverted when EPS = 0 (odd).
- STOP: drive 1 for 1 bit time, or 2 bit times when STB = 1.
- Then back to IDLE; back-to-back frames are sent with no gap.
- Config inputs are sampled at frame start and held for the whole frame.

Receiver FSM (IDLE, START, DATA, PARITY, STOP):
- UART_RX_I passes through a 2-flop synchronizer.
- IDLE: a falling edge starts START.
- START: after OSM/2 ticks (8 or 6), re-sample; if the line is high, return to IDLE (glitch); otherwise continue.
- All later samples are taken every OSM ticks from that mid-bit point.
- DATA: WLS+5 bits, LSB first, zero-extended to 8 bits.
- PARITY: one bit if PEN = 1.
- STOP: first stop bit sampled; STB = 1 expects a second stop bit.
- At the first stop-bit sample, the character is pushed into the RX FIFO if it is not full; otherwise it is discarded.
- Parity and framing errors are not reported; the data is stored anyway.
- Return to IDLE after the stop bit(s).

Loopback:
- With UART_RX_I tied to UART_TX_O, every pushed character (masked to WLS+5 bits) must reappear in RX order, for every legal config and any D in 27..1603.

Test Plan:
1. Reset: hold rst_n = 0 for 200 clks -> UART_TX_O = 1, tx_fifo_empty = rx_fifo_empty = 1, both full = 0, RBR_o = 0.
2. Baud and framing: D = 27, OSM_SEL = 0, WLS = 11, PEN = 0, STB = 0, push 0xA5 -> TX low for 432 clks, then bits 1,0,1,0,0,1,0,1 each 432 clks, then high; OSM_SEL = 1 gives 351-clk bits.
3. Parity and stop: WLS = 00, PEN = 1, EPS = 1, STB = 1, push 0x13 (5 bits 10011) -> parity bit 1, two stop bits; same with EPS = 0 -> parity bit 0.
4. TX FIFO full: with BGE = 0, push 17 bytes -> tx_fifo_full = 1 after the 16th, 17th ignored; after BGE = 1, exactly 16 frames are sent.
5. Loopback: random config, D = $urandom_range(27, 1603), stream 100 bytes throttled by tx_fifo_full, pop while !rx_fifo_empty -> received sequence equals sent bytes masked to WLS+5 bits.
6. RX overflow and glitch: receive 17 frames without popping -> rx_fifo_full = 1, 17th dropped, first 16 preserved in order; a low pulse on UART_RX_I shorter than OSM/2 ticks -> no character pushed.
